rob_mc: RTL and testbench

Parametrised, dual-retire reorder buffer for the out-of-order core. It sits between rename/dispatch and the architectural register file and free list. Entries are allocated in program order, results are written back out of order, and up to two completed entries retire per cycle in order. Beyond a basic single-retire ROB, it adds:
- selective flush of younger entries on branch mispredict;
- precise exception retirement;
- an exported occupancy count.

---
 rtl/rob_mc.sv | 133 +++++++++++++
 tb/tb_rob_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// rtl/rob_mc.sv - dual-retire reorder buffer with selective flush and precise exceptions
module rob_mc #(
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_valid,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic [PREG_W-1:0] alloc_dest,
  input  logic [PREG_W-1:0] alloc_old_dest,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              wb_exc,
  input  logic              flush_valid,
  input  logic [IDX_W-1:0]  flush_idx,
  input  logic              commit_ready,
  output logic              cm0_valid,
  output logic              cm1_valid,
  output logic [PREG_W-1:0] cm0_dest,
  output logic [PREG_W-1:0] cm1_dest,
  output logic [PREG_W-1:0] cm0_old_dest,
  output logic [PREG_W-1:0] cm1_old_dest,
  output logic [DATA_W-1:0] cm0_value,
  output logic [DATA_W-1:0] cm1_value,
  output logic              exc_valid,
  output logic [PC_W-1:0]   exc_pc,
  output logic [IDX_W:0]    count
);

  logic [DEPTH-1:0]  valid_q, done_q, exc_q;
  logic [PC_W-1:0]   pc_q       [DEPTH];
  logic [PREG_W-1:0] dest_q     [DEPTH];
  logic [PREG_W-1:0] old_dest_q [DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];

  logic [IDX_W-1:0] head, tail, head_n1, flush_next, keep_len, kill_len;
  logic [IDX_W:0]   count_q, flush_count;
  logic [DEPTH-1:0] kill;
  logic [1:0]       retire_n;
  logic             commit_ok, alloc_fire, wb_apply;

  assign head_n1   = head + 1'b1;
  assign commit_ok = commit_ready && !flush_valid;

  assign cm0_valid = commit_ok && valid_q[head] && done_q[head] && !exc_q[head];
  assign cm1_valid = cm0_valid && valid_q[head_n1] && done_q[head_n1] && !exc_q[head_n1];
  assign exc_valid = commit_ok && valid_q[head] && done_q[head] && exc_q[head];

  assign cm0_dest     = cm0_valid ? dest_q[head]        : '0;
  assign cm0_old_dest = cm0_valid ? old_dest_q[head]    : '0;
  assign cm0_value    = cm0_valid ? value_q[head]       : '0;
  assign cm1_dest     = cm1_valid ? dest_q[head_n1]     : '0;
  assign cm1_old_dest = cm1_valid ? old_dest_q[head_n1] : '0;
  assign cm1_value    = cm1_valid ? value_q[head_n1]    : '0;
  assign exc_pc       = exc_valid ? pc_q[head]          : '0;

  assign alloc_ready = (count_q != (IDX_W+1)'(DEPTH)) && !flush_valid && !exc_valid;
  assign alloc_idx   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign count       = count_q;
  assign retire_n    = {1'b0, cm0_valid} + {1'b0, cm1_valid};

  // Squashed range is flush_idx+1 .. tail-1; keep_len of zero means the kept part fills the ROB.
  assign flush_next  = flush_idx + 1'b1;
  assign keep_len    = flush_next - head;
  assign kill_len    = tail - flush_next;
  assign flush_count = (keep_len == '0 && count_q == (IDX_W+1)'(DEPTH)) ?
                       (IDX_W+1)'(DEPTH) : {1'b0, keep_len};

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_valid && ((IDX_W'(i) - flush_next) < kill_len))
        kill[i] = 1'b1;
    end
  end

  assign wb_apply = wb_valid && valid_q[wb_idx] && !kill[wb_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (wb_apply) begin
        done_q[wb_idx] <= 1'b1;
        exc_q[wb_idx]  <= wb_exc;
      end
      if (flush_valid) begin
        valid_q <= valid_q & ~kill;
        tail    <= flush_next;
        count_q <= flush_count;
      end else if (exc_valid) begin
        valid_q <= '0;
        head    <= tail;
        count_q <= '0;
      end else begin
        if (alloc_fire) begin
          valid_q[tail] <= 1'b1;
          done_q[tail]  <= 1'b0;
          exc_q[tail]   <= 1'b0;
          tail          <= tail + 1'b1;
        end
        if (cm0_valid) valid_q[head]    <= 1'b0;
        if (cm1_valid) valid_q[head_n1] <= 1'b0;
        head    <= head + {{(IDX_W-2){1'b0}}, retire_n};
        count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_n);
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind the valid/done bits.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail]       <= alloc_pc;
      dest_q[tail]     <= alloc_dest;
      old_dest_q[tail] <= alloc_old_dest;
    end
    if (wb_apply) value_q[wb_idx] <= wb_value;
  end

endmodule

// File: tb/tb_rob_mc.sv
// tb/tb_rob_mc.sv - randomized scoreboard bench for rob_mc against a queue-based model
module tb_rob_mc;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alloc_valid, alloc_ready;
  logic [31:0] alloc_pc;
  logic [5:0]  alloc_dest, alloc_old_dest, alloc_idx;
  logic        wb_valid, wb_exc;
  logic [5:0]  wb_idx;
  logic [31:0] wb_value;
  logic        flush_valid;
  logic [5:0]  flush_idx;
  logic        commit_ready;
  logic        cm0_valid, cm1_valid;
  logic [5:0]  cm0_dest, cm1_dest, cm0_old_dest, cm1_old_dest;
  logic [31:0] cm0_value, cm1_value;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic [6:0]  count;

  rob_mc dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_dest(alloc_dest),
    .alloc_old_dest(alloc_old_dest), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value), .wb_exc(wb_exc),
    .flush_valid(flush_valid), .flush_idx(flush_idx), .commit_ready(commit_ready),
    .cm0_valid(cm0_valid), .cm1_valid(cm1_valid),
    .cm0_dest(cm0_dest), .cm1_dest(cm1_dest),
    .cm0_old_dest(cm0_old_dest), .cm1_old_dest(cm1_old_dest),
    .cm0_value(cm0_value), .cm1_value(cm1_value),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] pc;
    logic [5:0]  dest;
    logic [5:0]  old;
    logic        done;
    logic        exc;
    logic [31:0] value;
  } ent_t;

  typedef struct {
    logic        c0, c1, xv, ar;
    logic [31:0] xpc;
    logic [6:0]  cnt;
    logic [5:0]  aidx;
  } stat_t;

  typedef struct {
    logic [5:0]  dest;
    logic [5:0]  old;
    logic [31:0] value;
  } ret_t;

  ent_t  rob[$];
  stat_t st_q[$];
  ret_t  cm_q[$];
  int    tail_m = 0;
  int    fpos   = 0;
  int    total  = 0;
  int    bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the ROB is a program-order queue; apply this cycle's rules to it.
  task automatic model_eval();
    stat_t st;
    int    sz, pos;
    logic  f, cr, e0;
    ent_t  ne;
    f  = flush_valid;
    cr = commit_ready && !f;
    sz = rob.size();
    e0 = (sz > 0) && rob[0].done;
    st.xv   = cr && e0 && rob[0].exc;
    st.c0   = cr && e0 && !rob[0].exc;
    st.c1   = st.c0 && (sz > 1) && rob[1].done && !rob[1].exc;
    st.ar   = (sz < DEPTH) && !f && !st.xv;
    st.xpc  = st.xv ? rob[0].pc : 32'h0;
    st.cnt  = 7'(sz);
    st.aidx = 6'(tail_m);
    st_q.push_back(st);
    if (st.c0) cm_q.push_back('{dest: rob[0].dest, old: rob[0].old, value: rob[0].value});
    if (st.c1) cm_q.push_back('{dest: rob[1].dest, old: rob[1].old, value: rob[1].value});

    if (wb_valid) begin
      pos = -1;
      for (int k = 0; k < rob.size(); k++) if (rob[k].idx == wb_idx) pos = k;
      if (pos >= 0 && (!f || pos <= fpos)) begin
        rob[pos].done  = 1'b1;
        rob[pos].exc   = wb_exc;
        rob[pos].value = wb_value;
      end
    end
    if (f) begin
      while (rob.size() > fpos + 1) void'(rob.pop_back());
      tail_m = (int'(flush_idx) + 1) % DEPTH;
    end else if (st.xv) begin
      rob.delete();
    end else begin
      if (st.c0) void'(rob.pop_front());
      if (st.c1) void'(rob.pop_front());
      if (alloc_valid && st.ar) begin
        ne.idx = 6'(tail_m); ne.pc = alloc_pc; ne.dest = alloc_dest; ne.old = alloc_old_dest;
        ne.done = 1'b0; ne.exc = 1'b0; ne.value = 32'h0;
        rob.push_back(ne);
        tail_m = (tail_m + 1) % DEPTH;
      end
    end
  endtask

  task automatic zero_inputs();
    alloc_valid = 0; alloc_pc = 0; alloc_dest = 0; alloc_old_dest = 0;
    wb_valid = 0; wb_idx = 0; wb_value = 0; wb_exc = 0;
    flush_valid = 0; flush_idx = 0; commit_ready = 0;
  endtask

  // mode 0: allocate only, no retirement; mode 1: random traffic; mode 2: reset pulse
  task automatic cycle(input int mode);
    @(posedge clk); #1;
    if (mode == 2) begin
      zero_inputs();
      reset_n = 1'b0;
      #1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_ready", 64'(alloc_ready), 64'd1);
      chk("reset_cm0", 64'(cm0_valid), 64'd0);
      rob.delete();
      tail_m = 0;
      #1 reset_n = 1'b1;
      model_eval();
      return;
    end
    alloc_valid    = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
    alloc_pc       = $urandom;
    alloc_dest     = 6'($urandom);
    alloc_old_dest = 6'($urandom);
    wb_valid       = (mode != 0) && ($urandom_range(0, 9) < 6);
    if (rob.size() > 0 && $urandom_range(0, 9) < 8)
      wb_idx = rob[$urandom_range(0, rob.size() - 1)].idx;
    else
      wb_idx = 6'($urandom);
    wb_value    = $urandom;
    wb_exc      = ($urandom_range(0, 24) == 0);
    flush_valid = (mode != 0) && (rob.size() > 0) && ($urandom_range(0, 39) == 0);
    fpos        = (rob.size() > 0) ? $urandom_range(0, rob.size() - 1) : 0;
    flush_idx   = (rob.size() > 0) ? rob[fpos].idx : 6'd0;
    commit_ready = (mode == 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
    model_eval();
  endtask

  initial begin : monitor
    stat_t s;
    ret_t  r;
    forever begin
      @(negedge clk);
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("cm0_valid", 64'(cm0_valid), 64'(s.c0));
        chk("cm1_valid", 64'(cm1_valid), 64'(s.c1));
        chk("exc_valid", 64'(exc_valid), 64'(s.xv));
        chk("exc_pc", 64'(exc_pc), 64'(s.xpc));
        chk("count", 64'(count), 64'(s.cnt));
        chk("alloc_ready", 64'(alloc_ready), 64'(s.ar));
        chk("alloc_idx", 64'(alloc_idx), 64'(s.aidx));
        if (!s.c0) chk("cm0_zero", {cm0_dest, cm0_old_dest, cm0_value}, 64'd0);
        if (!s.c1) chk("cm1_zero", {cm1_dest, cm1_old_dest, cm1_value}, 64'd0);
        if (cm0_valid) begin
          if (cm_q.size() == 0) chk("cm0_unexpected", 64'd1, 64'd0);
          else begin
            r = cm_q.pop_front();
            chk("cm0_payload", {cm0_dest, cm0_old_dest, cm0_value}, {r.dest, r.old, r.value});
          end
        end
        if (cm1_valid) begin
          if (cm_q.size() == 0) chk("cm1_unexpected", 64'd1, 64'd0);
          else begin
            r = cm_q.pop_front();
            chk("cm1_payload", {cm1_dest, cm1_old_dest, cm1_value}, {r.dest, r.old, r.value});
          end
        end
      end
    end
  end

  initial begin : driver
    zero_inputs();
    reset_n = 1'b0;
    #2;
    chk("init_count", 64'(count), 64'd0);
    chk("init_ready", 64'(alloc_ready), 64'd1);
    chk("init_idx", 64'(alloc_idx), 64'd0);
    chk("init_exc", 64'(exc_valid), 64'd0);
    #10 reset_n = 1'b1;
    for (int i = 0; i < 70; i++) cycle(0);
    for (int i = 0; i < 3000; i++) cycle(1);
    cycle(2);
    for (int i = 0; i < 40; i++) cycle(0);
    for (int i = 0; i < 2000; i++) cycle(1);
    cycle(2);
    @(posedge clk); #1 zero_inputs();
    repeat (3) @(negedge clk);
    chk("status_drained", 64'(st_q.size()), 64'd0);
    chk("commits_drained", 64'(cm_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
